// File: rtl/bullet_pool.sv
// bullet_pool: a pool of N_BULLETS projectiles that share one spawn point, one
// speed and one fire cooldown. Live bullets move once per frame strobe, up
// (DIR=0) or down (DIR=1). They retire when they leave the screen, and the
// external collision logic can kill a slot at any time through `hit`.
//
// Ports:
//   clk, rst           pixel clock, async active-high reset
//   frame              one-clk strobe at start of vblank
//   fire               level fire request, only looked at on frame strobes
//   speed              unsigned pixels per frame
//   spawn_x/spawn_y    signed spawn point
//   hit[i]             kill slot i (ignored when idle)
//   screen_x/screen_y  signed beam position
//   active[i]          slot i live
//   bullet_x/bullet_y  packed slot coordinates, slot 0 in the LSBs
//   fire_ack/fire_drop one-clk pulses: shot accepted / rejected (pool full)
//   drawing            beam inside any live bullet, 1 clk latency

// One bullet slot: position registers plus a two-state (idle/moving) machine.
// `in_box` is combinational and is registered by the pool.
module bullet_slot #(
  parameter int CW       = 16,
  parameter int V_RES    = 480,
  parameter int BULLET_W = 40,
  parameter int BULLET_H = 30,
  parameter int DIR      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame,
  input  logic                 hit,
  input  logic                 spawn,
  input  logic [7:0]           speed,
  input  logic signed [CW-1:0] spawn_x,
  input  logic signed [CW-1:0] spawn_y,
  input  logic signed [CW-1:0] screen_x,
  input  logic signed [CW-1:0] screen_y,
  output logic                 active,
  output logic signed [CW-1:0] x,
  output logic signed [CW-1:0] y,
  output logic                 in_box
);
  typedef enum logic {IDLE, MOVING} state_t;
  state_t state;

  // Edge and limit compares run one bit wider so that x+W / y+H cannot wrap.
  localparam logic signed [CW:0] W_EXT  = (CW+1)'(BULLET_W);
  localparam logic signed [CW:0] H_EXT  = (CW+1)'(BULLET_H);
  localparam logic signed [CW:0] VR_EXT = (CW+1)'(V_RES);

  logic signed [CW-1:0] spd, new_y;
  logic signed [CW:0]   new_y_ext, x_ext, y_ext, sx_ext, sy_ext;
  logic                 retire;

  always_comb begin
    spd       = $signed(CW'(speed));
    new_y     = (DIR == 0) ? y - spd : y + spd;
    new_y_ext = $signed({new_y[CW-1], new_y});
    retire    = (DIR == 0) ? (new_y_ext + H_EXT <= 0) : (new_y_ext >= VR_EXT);
    x_ext     = $signed({x[CW-1], x});
    y_ext     = $signed({y[CW-1], y});
    sx_ext    = $signed({screen_x[CW-1], screen_x});
    sy_ext    = $signed({screen_y[CW-1], screen_y});
    in_box    = active && (sx_ext >= x_ext) && (sx_ext < x_ext + W_EXT)
                       && (sy_ext >= y_ext) && (sy_ext < y_ext + H_EXT);
  end

  assign active = (state == MOVING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        MOVING: begin
          // hit wins over movement; a killed bullet keeps its last position
          if (hit) begin
            state <= IDLE;
          end else if (frame) begin
            y <= new_y;
            if (retire) state <= IDLE;
          end
        end
        default: begin
          if (spawn) begin
            state <= MOVING;
            x     <= spawn_x;
            y     <= spawn_y;
          end
        end
      endcase
    end
  end
endmodule

module bullet_pool #(
  parameter int N_BULLETS    = 4,
  parameter int SCREEN_CORDW = 16,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BULLET_W     = 40,
  parameter int BULLET_H     = 30,
  parameter int COOLDOWN     = 8,
  parameter int DIR          = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame,
  input  logic                                 fire,
  input  logic [7:0]                           speed,
  input  logic signed [SCREEN_CORDW-1:0]       spawn_x,
  input  logic signed [SCREEN_CORDW-1:0]       spawn_y,
  input  logic [N_BULLETS-1:0]                 hit,
  input  logic signed [SCREEN_CORDW-1:0]       screen_x,
  input  logic signed [SCREEN_CORDW-1:0]       screen_y,
  output logic [N_BULLETS-1:0]                 active,
  output logic [N_BULLETS*SCREEN_CORDW-1:0]    bullet_x,
  output logic [N_BULLETS*SCREEN_CORDW-1:0]    bullet_y,
  output logic                                 fire_ack,
  output logic                                 fire_drop,
  output logic                                 drawing
);
  localparam int CW  = SCREEN_CORDW;
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [CDW-1:0]       cd;
  logic [N_BULLETS-1:0] spawn_sel, spawn_en, in_box;
  logic                 any_free, shoot, take, drop;

  // Lowest-index slot that is free at the start of this cycle. Slots freed by
  // hit/retire in this same edge are still active here, so they wait a frame.
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!active[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
    end
    shoot    = frame && fire && (cd == '0);
    take     = shoot && any_free;
    drop     = shoot && !any_free;
    spawn_en = take ? spawn_sel : '0;
  end

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .CW(CW), .V_RES(V_RES), .BULLET_W(BULLET_W), .BULLET_H(BULLET_H), .DIR(DIR)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .frame    (frame),
      .hit      (hit[i]),
      .spawn    (spawn_en[i]),
      .speed    (speed),
      .spawn_x  (spawn_x),
      .spawn_y  (spawn_y),
      .screen_x (screen_x),
      .screen_y (screen_y),
      .active   (active[i]),
      .x        (bullet_x[i*CW +: CW]),
      .y        (bullet_y[i*CW +: CW]),
      .in_box   (in_box[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd        <= '0;
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
      drawing   <= 1'b0;
    end else begin
      fire_ack  <= take;
      fire_drop <= drop;
      drawing   <= |in_box;
      if (take)                    cd <= CDW'(COOLDOWN);
      else if (frame && cd != '0)  cd <= cd - 1'b1;
    end
  end
endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised successor to the single-shot bullet: manages a pool of N_BULLETS independent projectiles, sharing one spawn point, one speed and a fire cooldown.
- Moves all live bullets once per frame strobe, either upward (player shots) or downward (alien shots), and retires them when they leave the screen.
- Sits between the spaceship/alien controller and the collision and pixel-mux logic. Collision stays external; the collision logic kills individual slots through `hit`.
- Everything runs in the pixel clock domain; `frame` is a strobe, not a clock.

Parameters:
- N_BULLETS, 4, number of bullet slots (1..16).
- SCREEN_CORDW, 16, signed coordinate width.
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels.
- BULLET_W, 40, on-screen bullet width in pixels (sprite width × scale).
- BULLET_H, 30, on-screen bullet height in pixels.
- COOLDOWN, 8, frames that must elapse after an accepted shot before the next shot is accepted (0 = no cooldown).
- DIR, 0, direction of travel: 0 = up (y decreases), 1 = down (y increases).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame  in  1  one-clk pulse at start of vertical blank.
- fire  in  1  fire request, level, sampled only on frame pulses.
- speed  in  8  unsigned pixels moved per frame.
- spawn_x  in  SCREEN_CORDW  signed spawn x (shooter position).
- spawn_y  in  SCREEN_CORDW  signed spawn y.
- hit  in  N_BULLETS  per-slot kill from collision logic, any cycle.
- screen_x  in  SCREEN_CORDW  signed current beam x.
- screen_y  in  SCREEN_CORDW  signed current beam y.
- active  out  N_BULLETS  slot i is live.
- bullet_x  out  N_BULLETS*SCREEN_CORDW  packed slot x, slot 0 in the LSBs.
- bullet_y  out  N_BULLETS*SCREEN_CORDW  packed slot y.
- fire_ack  out  1  one-clk pulse: shot accepted.
- fire_drop  out  1  one-clk pulse: shot rejected because the pool is full.
- drawing  out  1  the beam is inside any active bullet.

Behaviour:
- Reset (asynchronous assert, release synchronous to clk): active = 0, all bullet_x/bullet_y = 0, cooldown counter = 0, fire_ack = 0, fire_drop = 0, drawing = 0. Reset dominates every other input.
- Per-slot state machine:
  - IDLE → MOVING on spawn.
  - MOVING → IDLE on hit[i], or on retire during a frame update.
  - active[i] = (state == MOVING).
- Kill via hit:
  - hit[i] while slot i is MOVING clears active[i] on the next clk edge. bullet_x/bullet_y hold their last value.
  - hit[i] on an IDLE slot is ignored.
  - hit takes priority over movement and retire in the same cycle.
- Frame update, all in the clk edge where frame = 1:
  - Movement, for each MOVING slot without hit:
    - new_y = y − speed if DIR = 0; new_y = y + speed if DIR = 1.
    - Arithmetic is signed SCREEN_CORDW; speed is zero-extended.
  - Retire:
    - DIR = 0: retire if new_y + BULLET_H <= 0.
    - DIR = 1: retire if new_y >= V_RES.
    - A retired slot goes IDLE; its y register is still loaded with new_y.
  - Spawn: if fire = 1 and cooldown = 0:
    - With at least one slot free at the start of this cycle: load the lowest-index free slot with spawn_x/spawn_y, set it active, load cooldown = COOLDOWN, pulse fire_ack.
    - The spawned bullet does not move on its spawn frame.
    - A slot freed by hit or retire in this same cycle is not eligible until the next frame.
    - With no slot free: pulse fire_drop. Cooldown is not reloaded.
  - fire while cooldown > 0: silently ignored (no ack, no drop).
  - Cooldown decrements by 1 on every frame pulse where it is > 0 and no shot is accepted.
- fire_ack and fire_drop are registered. Each is high for exactly the one cycle after the frame edge that accepted or dropped the shot.
- speed = 0: bullets stay put. Retire is still evaluated, so an off-screen bullet retires.
- drawing:
  - Registered, 1 clk latency from screen_x/screen_y.
  - drawing = OR over active slots of (bullet_x <= screen_x < bullet_x + BULLET_W) and (bullet_y <= screen_y < bullet_y + BULLET_H).
  - Compares are signed; negative coordinates are legal.
- Outputs change only on clk edges. No combinational path from inputs to outputs.

Test Plan:
1. Reset, then fire = 1, spawn = (100, 400), speed = 4, DIR = 0, one frame pulse → fire_ack pulses, active = 0001, slot0 = (100, 400). Next frame → y = 396. Frame after → y = 392.
2. COOLDOWN = 8, fire held high over 20 frames → acks on frames 0, 9 and 18 (every 9th frame), filling slots 0, 1, 2 in order. No fire_drop.
3. COOLDOWN = 0, fire held with all 4 slots live → 5th frame gives fire_drop, no ack, active = 1111. Then hit = 0100 → active = 1011 next clk. Next frame with fire: slot 2 reloaded, fire_ack pulses.
4. DIR = 0, y = 10, BULLET_H = 30, speed = 40 → new_y = −30, so the slot retires on that frame. With speed = 39 the slot stays active at y = −29.
5. DIR = 1, V_RES = 480, y = 476, speed = 4 → the slot retires. hit on the same cycle as the frame pulse → the slot clears with y unchanged (476).
6. Slot0 at (100, 400), BULLET_W = 40, BULLET_H = 30: beam at (139, 429) → drawing = 1 one clk later. Beam at (140, 429) or (100, 430) → drawing = 0. Assert rst mid-flight → active = 0 and drawing = 0 immediately, with no clk edge needed.
